// File: rtl/tsr_pkg.sv
// Shared definitions for the weight loader: FSM state encoding, header word
// indices, datapath widths and the header range check.
// Optional feature macro: WEIGHT_LOADER_CHECKSUM_EN (adds the TRAILER state).
package tsr_pkg;

    localparam int STREAM_WIDTH = 32;
    localparam int WEIGHT_WIDTH = 16;

    // Position of each header word within a frame
    localparam int HDR_BASE = 0;
    localparam int HDR_LEN  = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR_LEN = 3'd1,
        ST_DATA_LO = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DONE    = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_TRAILER = 3'd6
    } load_state_t;

    // A weight count is unusable when it is zero, too large, or would run
    // past the end of the address space. The 33-bit sum rejects wrap-around.
    function automatic logic len_invalid(
        input logic [STREAM_WIDTH-1:0] base,
        input logic [STREAM_WIDTH-1:0] len,
        input logic [STREAM_WIDTH:0]   addr_limit,
        input logic [STREAM_WIDTH-1:0] max_count
    );
        logic [STREAM_WIDTH:0] span;
        span = {1'b0, base} + {1'b0, len};
        return (len == '0) || (len > max_count) || (span > addr_limit);
    endfunction

endpackage

// File: rtl/weight_loader_unpacker.sv
// weight_unpacker: splits accepted 32-bit stream words into two registered
// 16-bit weight writes (low half first), walks the write address from the
// frame base and drops the upper half of the final word when N is odd.
// With WEIGHT_LOADER_CHECKSUM_EN it also keeps a wrapping sum of issued weights.
module weight_unpacker
    import tsr_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    base_load,
    input  logic [STREAM_WIDTH-1:0] base,
    input  logic                    len_load,
    input  logic [STREAM_WIDTH-1:0] len,
    input  logic                    word_load,
    input  logic [STREAM_WIDTH-1:0] word,
    input  logic                    hi_issue,
    output logic [WEIGHT_WIDTH-1:0] wr_data,
    output logic [STREAM_WIDTH-1:0] wr_addr,
    output logic                    wr_en,
    output logic [STREAM_WIDTH-1:0] addr,
    output logic                    last_word,
    output logic                    rem_one
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    ,
    output logic [WEIGHT_WIDTH-1:0] checksum
`endif
);

    logic [STREAM_WIDTH-1:0] addr_reg;
    logic [STREAM_WIDTH-1:0] rem_reg;     // weights still to be written
    logic [WEIGHT_WIDTH-1:0] hi_buf_reg;  // upper half waiting for its turn
    logic [WEIGHT_WIDTH-1:0] wr_data_reg;
    logic [STREAM_WIDTH-1:0] wr_addr_reg;
    logic                    wr_en_reg;

    logic                    issue_en;
    logic [WEIGHT_WIDTH-1:0] issue_data;

    // Choose the weight written next cycle: low half on a new word, otherwise
    // the buffered high half unless the count is already exhausted (odd N).
    always_comb begin
        issue_en   = 1'b0;
        issue_data = hi_buf_reg;
        if (word_load) begin
            issue_en   = 1'b1;
            issue_data = word[WEIGHT_WIDTH-1:0];
        end else if (hi_issue && (rem_reg != '0)) begin
            issue_en   = 1'b1;
        end
    end

    // Half-buffer, address counter, remaining count and registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg    <= '0;
            rem_reg     <= '0;
            hi_buf_reg  <= '0;
            wr_data_reg <= '0;
            wr_addr_reg <= '0;
            wr_en_reg   <= 1'b0;
        end else begin
            wr_en_reg <= issue_en;
            if (base_load) begin
                addr_reg <= base;
            end
            if (len_load) begin
                rem_reg <= len;
            end
            if (word_load) begin
                hi_buf_reg <= word[STREAM_WIDTH-1:WEIGHT_WIDTH];
            end
            if (issue_en) begin
                wr_data_reg <= issue_data;
                wr_addr_reg <= addr_reg;
                addr_reg    <= addr_reg + 1'b1;
                rem_reg     <= rem_reg - 1'b1;
            end
        end
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [WEIGHT_WIDTH-1:0] sum_reg;

    // Running sum is updated as each write is issued so it is complete by
    // the time the trailer can be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg <= '0;
        end else if (base_load) begin
            sum_reg <= '0;
        end else if (issue_en) begin
            sum_reg <= sum_reg + issue_data;
        end
    end

    assign checksum = sum_reg;
`endif

    assign wr_data   = wr_data_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_en     = wr_en_reg;
    assign addr      = addr_reg;
    // Word about to be accepted is the final data word of the frame
    assign last_word = (rem_reg <= STREAM_WIDTH'(2));
    assign rem_one   = (rem_reg == STREAM_WIDTH'(1));

endmodule

// File: rtl/weight_loader.sv
// weight_loader: accepts a framed 32-bit weight stream (base, N, data words)
// and drives the conv weight write port with one 16-bit write per cycle.
// Optional feature macro: WEIGHT_LOADER_CHECKSUM_EN adds a checksum trailer
// word after the data; load_done then requires a matching sum.
module weight_loader
    import tsr_pkg::*;
#(
    parameter int unsigned ADDR_LIMIT = 65536,
    parameter int unsigned MAX_COUNT  = 32768
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [STREAM_WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_last,
    output logic [WEIGHT_WIDTH-1:0] weight_wr_data,
    output logic [STREAM_WIDTH-1:0] weight_wr_addr,
    output logic                    weight_wr_en,
    output logic                    load_busy,
    output logic                    load_done,
    output logic                    load_err
);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    localparam load_state_t TAIL_STATE = ST_TRAILER;
`else
    localparam load_state_t TAIL_STATE = ST_DONE;
`endif

    load_state_t state_reg, state_next;

    logic load_err_reg, load_done_reg;
    logic err_set, err_clr, done_set;
    logic base_load, len_load, word_load, hi_issue;
    logic [STREAM_WIDTH-1:0] cur_addr;
    logic last_word, rem_one;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [WEIGHT_WIDTH-1:0] checksum;
`endif

    weight_unpacker u_unpacker (
        .clk       (clk),
        .rst_n     (rst_n),
        .base_load (base_load),
        .base      (s_data),
        .len_load  (len_load),
        .len       (s_data),
        .word_load (word_load),
        .word      (s_data),
        .hi_issue  (hi_issue),
        .wr_data   (weight_wr_data),
        .wr_addr   (weight_wr_addr),
        .wr_en     (weight_wr_en),
        .addr      (cur_addr),
        .last_word (last_word),
        .rem_one   (rem_one)
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    // Frame sequencing: header capture, data word pacing, error handling
    always_comb begin
        state_next = state_reg;
        s_ready    = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        done_set   = 1'b0;
        base_load  = 1'b0;
        len_load   = 1'b0;
        word_load  = 1'b0;
        hi_issue   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (s_last) begin
                        err_set = 1'b1;
                    end else begin
                        err_clr    = 1'b1;
                        base_load  = 1'b1;
                        state_next = ST_HDR_LEN;
                    end
                end
            end
            ST_HDR_LEN: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (s_last) begin
                        err_set    = 1'b1;
                        state_next = ST_IDLE;
                    end else if (len_invalid(cur_addr, s_data, (STREAM_WIDTH+1)'(ADDR_LIMIT),
                                             STREAM_WIDTH'(MAX_COUNT))) begin
                        err_set    = 1'b1;
                        state_next = ST_DRAIN;
                    end else begin
                        len_load   = 1'b1;
                        state_next = ST_DATA_LO;
                    end
                end
            end
            ST_DATA_LO: begin
                s_ready = 1'b1;
                if (s_valid) begin
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                    // The trailer carries s_last, so it is early on any data word
                    if (s_last) begin
                        err_set    = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        word_load  = 1'b1;
                        state_next = rem_one ? TAIL_STATE : ST_DATA_HI;
                    end
`else
                    if (s_last && !last_word) begin
                        err_set    = 1'b1;
                        state_next = ST_IDLE;
                    end else if (!s_last && last_word) begin
                        err_set    = 1'b1;
                        state_next = ST_DRAIN;
                    end else begin
                        word_load  = 1'b1;
                        state_next = rem_one ? TAIL_STATE : ST_DATA_HI;
                    end
`endif
                end
            end
            ST_DATA_HI: begin
                hi_issue   = 1'b1;
                state_next = rem_one ? TAIL_STATE : ST_DATA_LO;
            end
            ST_DONE: begin
                done_set   = 1'b1;
                state_next = ST_IDLE;
            end
            ST_DRAIN: begin
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    state_next = ST_IDLE;
                end
            end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            ST_TRAILER: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (s_last && (s_data[WEIGHT_WIDTH-1:0] == checksum)) begin
                        state_next = ST_DONE;
                    end else begin
                        err_set    = 1'b1;
                        state_next = s_last ? ST_IDLE : ST_DRAIN;
                    end
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register plus the sticky error flag and the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            load_err_reg  <= 1'b0;
            load_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            load_done_reg <= done_set;
            if (err_set) begin
                load_err_reg <= 1'b1;
            end else if (err_clr) begin
                load_err_reg <= 1'b0;
            end
        end
    end

    assign load_busy = (state_reg != ST_IDLE);
    assign load_done = load_done_reg;
    assign load_err  = load_err_reg;

endmodule
